phase_sequencer: RTL and testbench
==================================

Name: phase_sequencer

Overview:
- Upstream timing stage for the multi-phase control decoder.
- Generates the 3-bit `phase` that the decoder consumes, and controls run, stop, single-step and halt at instruction boundaries.
- Synchronises the front-panel buttons, detects HLT from the fetched instruction, and counts retired instructions.
- Phase 0 means "no instruction in flight"; the decoder treats phase 0 as inactive.

Parameters:
NUM_PHASES, 5, phases per instruction (P1..P5, encoded 1..NUM_PHASES)
PH_W, 3, phase bus width; must satisfy 2^PH_W > NUM_PHASES
CNT_W, 16, retired-instruction counter width
SYNC_STAGES, 2, synchroniser depth for each button input (>=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start_btn  in  1  raw async button level, run request
stop_btn  in  1  raw async button level, stop request
step_btn  in  1  raw async button level, single-instruction request
instruction  in  16  current IR contents, stable from end of P1 through P5
phase  out  PH_W  current phase: 0 = idle/halted, 1..NUM_PHASES = active
running  out  1  high in RUN or STEP state
halted  out  1  high in HALTED state
last_phase  out  1  high when phase == NUM_PHASES
instr_count  out  CNT_W  retired-instruction count

Behaviour:
Reset:
- rst low forces immediately, regardless of clk: state IDLE, phase=0, running=0, halted=0, last_phase=0, instr_count=0, stop_pending=0, all synchroniser flops 0.
- Reset mid-instruction abandons the instruction; it is not counted.

Button path:
- Each button passes through a SYNC_STAGES flop chain, then rising-edge detection: pulse = sync_out & ~sync_prev.
- A level sampled high at edge k produces a state change at edge k+SYNC_STAGES. With SYNC_STAGES=2, phase reads 1 after edge k+2.
- A held button yields exactly one pulse.

States: IDLE, RUN, STEP, HALTED.
- IDLE:
  - start pulse -> RUN, phase=1.
  - step pulse -> STEP, phase=1.
  - start and step together -> RUN.
  - stop pulse in the same cycle as start or step -> remain IDLE (stop wins).
- RUN / STEP, phase advance: phase increments by 1 each cycle, 1 -> 2 -> ... -> NUM_PHASES.
- At phase == NUM_PHASES, evaluated in this priority order:
  1. HLT detected (instruction[15:14]==2'b11 and instruction[7:4]==4'b1111) -> HALTED, phase=0, instr_count unchanged.
  2. Otherwise instr_count += 1, wrapping modulo 2^CNT_W. Then:
     - STEP, or RUN with stop_pending (or a stop pulse this cycle) -> IDLE, phase=0, clear stop_pending.
     - Otherwise RUN continues, phase=1.
- stop_pending: a stop pulse in RUN at phase < NUM_PHASES sets it. Stop never truncates an instruction.
- Ignored pulses:
  - start and step pulses in RUN/STEP are ignored.
  - stop pulses in STEP are ignored; a step always completes.
- HALTED: phase=0, halted=1; all button pulses are ignored. Only rst leaves HALTED.
- Outputs:
  - phase, running, halted, instr_count are registered.
  - last_phase is combinational from the phase register.
- instruction is sampled only at phase NUM_PHASES; its value is don't-care in other phases.

Decomposition:
- Shared package (ctrl_pkg):
  - phase encodings: PH_IDLE=0, PH_P1..PH_P5
  - sequencer state enum
  - OP_ALU=2'b11, ALU_HLT=4'b1111
  - the 16-bit instruction field slice positions, shared with the control decoder
- One sub-module, button_sync_edge: parameter SYNC_STAGES; ports clk, rst, btn_in, pulse_out. Instantiated three times.

Test Plan:
- Reset, then start_btn high 1 cycle at edge k, instruction=16'hC000 (ADD) -> phase 0 until edge k+2, then 1,2,3,4,5,1,2,...; instr_count increments at each phase-5 exit; running=1.
- From IDLE, step_btn pulse, instruction=16'hC000 -> phase 1..5 once, then 0; instr_count=1; running drops after phase 5.
- RUN, stop_btn pulse while phase=2 -> phase continues 3,4,5 then 0; instr_count incremented once for that instruction; state IDLE.
- RUN, instruction=16'hC0F0 (HLT) at phase 5 -> phase=0, halted=1, instr_count unchanged; later start/step pulses leave phase at 0; rst low clears halted.
- rst asserted asynchronously mid-phase 3 -> all outputs read reset values before the next clk edge; no count increment.
- CNT_W=4, run 17 ADD instructions from reset -> instr_count reads 4'hF after 15, wraps to 0 after 16, reads 1 after 17.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the phase sequencer and the multi-phase control decoder.
// Holds the phase encodings, the sequencer state type, the opcode/function values
// that identify HLT, and the bit positions of the instruction fields.
package ctrl_pkg;

  // Phase encodings; PH_IDLE means no instruction in flight.
  localparam logic [2:0] PH_IDLE = 3'd0;
  localparam logic [2:0] PH_P1   = 3'd1;
  localparam logic [2:0] PH_P2   = 3'd2;
  localparam logic [2:0] PH_P3   = 3'd3;
  localparam logic [2:0] PH_P4   = 3'd4;
  localparam logic [2:0] PH_P5   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_HALTED
  } seq_state_t;

  localparam logic [1:0] OP_ALU  = 2'b11;
  localparam logic [3:0] ALU_HLT = 4'b1111;

  // Instruction field slice positions (16-bit IR).
  localparam int unsigned OP_MSB = 15;
  localparam int unsigned OP_LSB = 14;
  localparam int unsigned FN_MSB = 7;
  localparam int unsigned FN_LSB = 4;

  function automatic logic is_hlt(input logic [15:0] instr);
    return (instr[OP_MSB:OP_LSB] == OP_ALU) && (instr[FN_MSB:FN_LSB] == ALU_HLT);
  endfunction

endpackage

// File: rtl/button_sync_edge.sv
// Front-panel button conditioner: SYNC_STAGES-deep synchroniser followed by a
// rising-edge detector, so a held button produces exactly one clk-wide pulse.
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   btn_in    raw asynchronous button level
//   pulse_out one-cycle pulse on a synchronised rising edge
module button_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse_out = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/phase_sequencer.sv
// Timing stage ahead of the multi-phase control decoder. Steps the phase bus
// through 1..NUM_PHASES per instruction, handles run/stop/single-step from the
// front panel at instruction boundaries, halts on HLT and counts retired
// instructions.
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   start_btn    raw button, run request
//   stop_btn     raw button, stop at next instruction boundary
//   step_btn     raw button, execute one instruction
//   instruction  current IR contents (sampled at the last phase only)
//   phase        0 = idle/halted, 1..NUM_PHASES = active phase
//   running      high in RUN or STEP
//   halted       high once HLT has retired
//   last_phase   high while phase == NUM_PHASES
//   instr_count  retired-instruction count, wraps
module phase_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned NUM_PHASES  = 5,
  parameter int unsigned PH_W        = 3,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_btn,
  input  logic             stop_btn,
  input  logic             step_btn,
  input  logic [15:0]      instruction,
  output logic [PH_W-1:0]  phase,
  output logic             running,
  output logic             halted,
  output logic             last_phase,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [PH_W-1:0] PH_NONE  = PH_W'(PH_IDLE);
  localparam logic [PH_W-1:0] PH_FIRST = PH_W'(1);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(NUM_PHASES);

  logic start_p, stop_p, step_p;

  button_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
    .clk(clk), .rst(rst), .btn_in(start_btn), .pulse_out(start_p)
  );
  button_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_stop_sync (
    .clk(clk), .rst(rst), .btn_in(stop_btn), .pulse_out(stop_p)
  );
  button_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
    .clk(clk), .rst(rst), .btn_in(step_btn), .pulse_out(step_p)
  );

  seq_state_t       state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             stop_pend_q, stop_pend_d;
  logic             running_q, halted_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      count_q     <= '0;
      stop_pend_q <= 1'b0;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      count_q     <= count_d;
      stop_pend_q <= stop_pend_d;
      // Status flags registered from the next state so they align with phase.
      running_q   <= (state_d == ST_RUN) || (state_d == ST_STEP);
      halted_q    <= (state_d == ST_HALTED);
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    count_d     = count_q;
    stop_pend_d = stop_pend_q;

    unique case (state_q)
      ST_IDLE: begin
        // A simultaneous stop cancels start/step.
        if (!stop_p) begin
          if (start_p) begin
            state_d = ST_RUN;
            phase_d = PH_FIRST;
          end else if (step_p) begin
            state_d = ST_STEP;
            phase_d = PH_FIRST;
          end
        end
      end

      ST_RUN, ST_STEP: begin
        if (phase_q == PH_LAST) begin
          if (is_hlt(instruction)) begin
            state_d     = ST_HALTED;
            phase_d     = PH_NONE;
            stop_pend_d = 1'b0;
          end else begin
            count_d = count_q + CNT_W'(1);
            if ((state_q == ST_STEP) || stop_pend_q || stop_p) begin
              state_d     = ST_IDLE;
              phase_d     = PH_NONE;
              stop_pend_d = 1'b0;
            end else begin
              phase_d = PH_FIRST;
            end
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
          // Stop only takes effect at the instruction boundary; steps ignore it.
          if ((state_q == ST_RUN) && stop_p) begin
            stop_pend_d = 1'b1;
          end
        end
      end

      ST_HALTED: begin
        phase_d = PH_NONE;
      end

      default: begin
        state_d = ST_IDLE;
        phase_d = PH_NONE;
      end
    endcase
  end

  assign phase       = phase_q;
  assign running     = running_q;
  assign halted      = halted_q;
  assign instr_count = count_q;
  assign last_phase  = (phase_q == PH_LAST);

endmodule

// File: tb/tb_phase_sequencer.sv
module tb_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_btn, stop_btn, step_btn;
  logic [15:0] instruction;
  logic [2:0]  phase;
  logic        running, halted, last_phase;
  logic [15:0] instr_count;

  logic        start4, stop4, step4;
  logic [2:0]  phase4;
  logic        running4, halted4, last4;
  logic [3:0]  count4;

  int total  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  phase_sequencer dut (
    .clk(clk), .rst(rst),
    .start_btn(start_btn), .stop_btn(stop_btn), .step_btn(step_btn),
    .instruction(instruction),
    .phase(phase), .running(running), .halted(halted),
    .last_phase(last_phase), .instr_count(instr_count)
  );

  phase_sequencer #(.CNT_W(4)) dut_w4 (
    .clk(clk), .rst(rst),
    .start_btn(start4), .stop_btn(stop4), .step_btn(step4),
    .instruction(instruction),
    .phase(phase4), .running(running4), .halted(halted4),
    .last_phase(last4), .instr_count(count4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    start_btn = 1'b0; stop_btn = 1'b0; step_btn = 1'b0;
    start4 = 1'b0; stop4 = 1'b0; step4 = 1'b0;
    instruction = 16'hC000;

    // Reset state
    repeat (3) tick();
    check("rst_phase", 32'(phase), 0);
    check("rst_running", 32'(running), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_last", 32'(last_phase), 0);
    check("rst_count", 32'(instr_count), 0);
    rst = 1'b1;
    tick();

    // Run: start sampled at edge k, phase 1 after edge k+2
    start_btn = 1'b1; tick(); start_btn = 1'b0;
    tick();
    check("run_lat_k1", 32'(phase), 0);
    tick();
    check("run_p1", 32'(phase), 1);
    check("run_running", 32'(running), 1);
    for (int p = 2; p <= 5; p++) begin
      tick();
      check("run_phase", 32'(phase), 32'(p));
    end
    check("run_last", 32'(last_phase), 1);
    tick();
    check("run_wrap_p1", 32'(phase), 1);
    check("run_count1", 32'(instr_count), 1);
    check("run_last_clr", 32'(last_phase), 0);
    repeat (5) tick();
    check("run_p1_b", 32'(phase), 1);
    check("run_count2", 32'(instr_count), 2);

    // Stop mid-instruction completes it then idles
    stop_btn = 1'b1; tick(); stop_btn = 1'b0;
    check("stop_p2", 32'(phase), 2);
    for (int p = 3; p <= 5; p++) begin
      tick();
      check("stop_phase", 32'(phase), 32'(p));
    end
    tick();
    check("stop_idle", 32'(phase), 0);
    check("stop_count", 32'(instr_count), 3);
    check("stop_running", 32'(running), 0);
    repeat (2) tick();
    check("stop_stay", 32'(phase), 0);

    // Start together with stop in IDLE: stop wins
    start_btn = 1'b1; stop_btn = 1'b1; tick();
    start_btn = 1'b0; stop_btn = 1'b0;
    repeat (3) tick();
    check("startstop_phase", 32'(phase), 0);
    check("startstop_run", 32'(running), 0);

    // Single step, with a start press during the step that must be ignored
    step_btn = 1'b1; tick(); step_btn = 1'b0;
    tick();
    check("step_lat", 32'(phase), 0);
    tick();
    check("step_p1", 32'(phase), 1);
    check("step_running", 32'(running), 1);
    tick();
    check("step_p2", 32'(phase), 2);
    start_btn = 1'b1; tick(); start_btn = 1'b0;
    check("step_p3", 32'(phase), 3);
    tick(); check("step_p4", 32'(phase), 4);
    tick(); check("step_p5", 32'(phase), 5);
    tick();
    check("step_idle", 32'(phase), 0);
    check("step_count", 32'(instr_count), 4);
    check("step_running_drop", 32'(running), 0);
    repeat (2) tick();
    check("step_stay", 32'(phase), 0);

    // HLT retires into HALTED without counting
    instruction = 16'hC0F0;
    start_btn = 1'b1; tick(); start_btn = 1'b0;
    tick(); tick();
    check("hlt_p1", 32'(phase), 1);
    repeat (4) tick();
    check("hlt_p5", 32'(phase), 5);
    tick();
    check("hlt_phase", 32'(phase), 0);
    check("hlt_halted", 32'(halted), 1);
    check("hlt_running", 32'(running), 0);
    check("hlt_count", 32'(instr_count), 4);
    start_btn = 1'b1; step_btn = 1'b1; tick();
    start_btn = 1'b0; step_btn = 1'b0;
    repeat (4) tick();
    check("hlt_ignore_phase", 32'(phase), 0);
    check("hlt_ignore_halted", 32'(halted), 1);

    // Async reset clears halted without a clock edge
    #2 rst = 1'b0;
    #1;
    check("hlt_rst_halted", 32'(halted), 0);
    check("hlt_rst_count", 32'(instr_count), 0);
    #1 rst = 1'b1;

    // Async reset mid-phase 3 abandons the instruction
    instruction = 16'hC000;
    tick();
    start_btn = 1'b1; tick(); start_btn = 1'b0;
    tick(); tick();
    check("ar_p1", 32'(phase), 1);
    repeat (5) tick();
    check("ar_count1", 32'(instr_count), 1);
    tick(); tick();
    check("ar_p3", 32'(phase), 3);
    #2 rst = 1'b0;
    #1;
    check("ar_phase", 32'(phase), 0);
    check("ar_running", 32'(running), 0);
    check("ar_last", 32'(last_phase), 0);
    check("ar_halted", 32'(halted), 0);
    check("ar_count", 32'(instr_count), 0);
    #1 rst = 1'b1;
    tick();
    check("ar_post_phase", 32'(phase), 0);
    check("ar_post_count", 32'(instr_count), 0);

    // 4-bit counter wraps after 16 instructions
    start4 = 1'b1; tick(); start4 = 1'b0;
    tick(); tick();
    check("w4_p1", 32'(phase4), 1);
    for (int n = 1; n <= 17; n++) begin
      repeat (5) tick();
      check("w4_count", 32'(count4), 32'(n % 16));
    end
    check("w4_running", 32'(running4), 1);

    $display("%0d/%0d checks passed", total - failed, total);
    $finish;
  end

endmodule
